// File: rtl/dadda_mul_arbiter_if.sv
// Bus bundle between N_REQ requesters, the shared multiplier and the single result consumer.
// The arbiter takes the slave view; the environment takes the master view.
interface dadda_mul_arbiter_if #(
  parameter int BIT_NUM = 11,
  parameter int N_REQ   = 4,
  parameter int P_W     = 2*BIT_NUM+1,
  parameter int ID_W    = $clog2(N_REQ)
);
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*BIT_NUM-1:0] req_a;
  logic [N_REQ*BIT_NUM-1:0] req_b;
  logic signed [BIT_NUM-1:0] mul_a;
  logic signed [BIT_NUM-1:0] mul_b;
  logic                     mul_en;
  logic signed [P_W-1:0]    mul_p;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [P_W-1:0]    out_p;
  logic [ID_W-1:0]          out_id;
  logic                     busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_p, out_ready,
    output req_ready, mul_a, mul_b, mul_en, out_valid, out_p, out_id, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_p, out_ready,
    input  req_ready, mul_a, mul_b, mul_en, out_valid, out_p, out_id, busy
  );
endinterface

// File: rtl/dadda_mul_arbiter.sv
// Round-robin front end for one shared pipelined signed multiplier; a tag pipeline
// matched to the multiplier depth returns each product with its requester ID.
module dadda_mul_arbiter #(
  parameter int BIT_NUM = 11,
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 2,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic clk,
  input  logic rst,
  dadda_mul_arbiter_if.slave bus
);

  logic [MUL_LAT-1:0] r_vld_sr;
  logic [ID_W-1:0]    r_id_sr [MUL_LAT];
  logic [ID_W-1:0]    r_rr_ptr;

  logic               w_any;
  logic [ID_W-1:0]    w_gnt;
  logic               w_issue;
  logic [N_REQ-1:0]   w_onehot;

  // Explicit modulo wrap so non-power-of-two N_REQ never yields an index >= N_REQ.
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  assign bus.mul_en = rst | !(r_vld_sr[MUL_LAT-1] && !bus.out_ready);

  // Searching from the far end lets the requester nearest rr_ptr win.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      if (bus.req_valid[wrap_idx(r_rr_ptr, k)]) begin
        w_any = 1'b1;
        w_gnt = wrap_idx(r_rr_ptr, k);
      end
    end
  end

  assign w_issue = w_any && bus.mul_en && !rst;

  always_comb begin
    w_onehot = '0;
    if (w_issue) w_onehot[w_gnt] = 1'b1;
  end

  assign bus.req_ready = w_onehot;
  assign bus.mul_a     = w_issue ? bus.req_a[w_gnt*BIT_NUM +: BIT_NUM] : '0;
  assign bus.mul_b     = w_issue ? bus.req_b[w_gnt*BIT_NUM +: BIT_NUM] : '0;

  assign bus.out_valid = r_vld_sr[MUL_LAT-1] && !rst;
  assign bus.out_id    = r_id_sr[MUL_LAT-1];
  assign bus.out_p     = bus.mul_p;
  assign bus.busy      = (|r_vld_sr) && !rst;

  // Tag pipeline: advances in lockstep with the multiplier registers via mul_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_sr <= '0;
      r_rr_ptr <= '0;
      for (int k = 0; k < MUL_LAT; k++) r_id_sr[k] <= '0;
    end else if (bus.mul_en) begin
      r_vld_sr[0] <= w_issue;
      r_id_sr[0]  <= w_gnt;
      for (int k = 1; k < MUL_LAT; k++) begin
        r_vld_sr[k] <= r_vld_sr[k-1];
        r_id_sr[k]  <= r_id_sr[k-1];
      end
      if (w_issue) r_rr_ptr <= (w_gnt == ID_W'(N_REQ-1)) ? '0 : w_gnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// Bench for dadda_mul_arbiter: behavioural pipelined multiplier plus a tagged-product scoreboard.
module tb_dadda_mul_arbiter;
  localparam int BIT_NUM = 11;
  localparam int N_REQ   = 4;
  localparam int MUL_LAT = 2;
  localparam int P_W     = 2*BIT_NUM+1;
  localparam int ID_W    = $clog2(N_REQ);

  typedef struct {
    logic [ID_W-1:0]       id;
    logic signed [P_W-1:0] p;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dadda_mul_arbiter_if #(.BIT_NUM(BIT_NUM), .N_REQ(N_REQ), .P_W(P_W), .ID_W(ID_W)) bus();

  dadda_mul_arbiter #(.BIT_NUM(BIT_NUM), .N_REQ(N_REQ), .MUL_LAT(MUL_LAT), .ID_W(ID_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference multiplier pipeline, frozen by mul_en like the real tree.
  logic signed [P_W-1:0] mp [MUL_LAT];
  always @(posedge clk) begin
    if (bus.mul_en) begin
      mp[0] <= bus.mul_a * bus.mul_b;
      for (int k = 1; k < MUL_LAT; k++) mp[k] <= mp[k-1];
    end
  end
  assign bus.mul_p = mp[MUL_LAT-1];

  logic signed [BIT_NUM-1:0] op_a [N_REQ];
  logic signed [BIT_NUM-1:0] op_b [N_REQ];
  always_comb begin
    bus.req_a = '0;
    bus.req_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_a[i*BIT_NUM +: BIT_NUM] = op_a[i];
      bus.req_b[i*BIT_NUM +: BIT_NUM] = op_b[i];
    end
  end

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [N_REQ-1:0]          s_vld, s_rdy;
  logic                      s_ov, s_ordy, s_en, s_busy;
  logic signed [P_W-1:0]     s_op;
  logic [ID_W-1:0]           s_oid;
  logic signed [BIT_NUM-1:0] s_ma, s_mb;

  // Samples at the falling edge, records handshakes, then steps past the next rising edge.
  task automatic tick();
    exp_t e;
    int pa, pb;
    @(negedge clk);
    s_vld = bus.req_valid; s_rdy = bus.req_ready;
    s_ov = bus.out_valid;  s_ordy = bus.out_ready;
    s_op = bus.out_p;      s_oid = bus.out_id;
    s_en = bus.mul_en;     s_busy = bus.busy;
    s_ma = bus.mul_a;      s_mb = bus.mul_b;
    for (int i = 0; i < N_REQ; i++) begin
      if (s_vld[i] && s_rdy[i]) begin
        pa = op_a[i]; pb = op_b[i];
        e.id = ID_W'(i);
        e.p  = P_W'(pa * pb);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < N_REQ; i++) begin
      op_a[i] = BIT_NUM'($urandom);
      op_b[i] = BIT_NUM'($urandom);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.out_ready = 1'b1; bus.req_valid = '1;
    randomize_ops();
    repeat (2) begin
      tick();
      n_vec++;
      if ({s_rdy, s_ov, s_busy, s_en} !== 7'b0000_001 || s_ma !== '0 || s_mb !== '0) begin
        n_err++;
        $display("FAIL reset_hold rdy=%b ov=%b busy=%b en=%b a=%0d b=%0d exp rdy=0000 ov=0 busy=0 en=1 a=0 b=0",
                 s_rdy, s_ov, s_busy, s_en, s_ma, s_mb);
      end
    end
    rst = 1'b0; bus.req_valid = '0;
    repeat (10) begin
      tick();
      n_vec++;
      if ({s_rdy, s_ov, s_busy, s_en} !== 7'b0000_001) begin
        n_err++;
        $display("FAIL idle rdy=%b ov=%b busy=%b en=%b exp 0000 0 0 1", s_rdy, s_ov, s_busy, s_en);
      end
    end
  endtask

  task automatic test_single();
    int va [2] = '{-1024, 1023};
    int vb [2] = '{-1024, -1};
    int vp [2] = '{1048576, -1023};
    exp_t e;
    for (int v = 0; v < 2; v++) begin
      op_a[2] = BIT_NUM'(va[v]); op_b[2] = BIT_NUM'(vb[v]);
      bus.req_valid = 4'b0100;
      tick();
      n_vec++;
      if (s_rdy !== 4'b0100 || s_ma !== op_a[2] || s_mb !== op_b[2]) begin
        n_err++;
        $display("FAIL single_grant rdy=%b a=%0d b=%0d exp 0100 %0d %0d", s_rdy, s_ma, s_mb, op_a[2], op_b[2]);
      end
      bus.req_valid = '0;
      tick();
      n_vec++;
      if (s_ov !== 1'b0) begin n_err++; $display("FAIL single_early ov=%b exp 0", s_ov); end
      tick();
      n_vec++;
      if (s_ov !== 1'b1 || s_op !== P_W'(vp[v]) || s_oid !== 2'd2) begin
        n_err++;
        $display("FAIL single_result ov=%b p=%0d id=%0d exp 1 %0d 2", s_ov, s_op, s_oid, vp[v]);
      end
      if (s_ov && s_ordy) begin
        n_vec++;
        if (sb.size() == 0) begin n_err++; $display("FAIL single_sb unexpected p=%0d id=%0d", s_op, s_oid); end
        else begin
          e = sb.pop_front();
          if (s_op !== e.p || s_oid !== e.id) begin
            n_err++; $display("FAIL single_sb got p=%0d id=%0d exp p=%0d id=%0d", s_op, s_oid, e.p, e.id);
          end
        end
      end
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    rst = 1'b1; tick(); rst = 1'b0;
    sb.delete();
    bus.req_valid = '1;
    for (int k = 0; k < 19; k++) begin
      if (k == 16) bus.req_valid = '0;
      randomize_ops();
      if (k == 3) begin op_a[1] = -11'sd1024; op_b[1] = 11'sd1023; end
      tick();
      if (k < 16) begin
        n_vec++;
        if (s_rdy !== (4'b0001 << (k % 4))) begin
          n_err++; $display("FAIL rr_grant k=%0d rdy=%b exp %b", k, s_rdy, 4'b0001 << (k % 4));
        end
      end
      if (k >= 2 && k < 18) begin
        n_vec++;
        if (s_ov !== 1'b1 || s_oid !== ID_W'((k-2) % 4)) begin
          n_err++; $display("FAIL rr_outid k=%0d ov=%b id=%0d exp 1 %0d", k, s_ov, s_oid, (k-2) % 4);
        end
      end
      if (s_ov && s_ordy) begin
        n_vec++;
        if (sb.size() == 0) begin n_err++; $display("FAIL rr_sb unexpected p=%0d id=%0d", s_op, s_oid); end
        else begin
          e = sb.pop_front();
          if (s_op !== e.p || s_oid !== e.id) begin
            n_err++; $display("FAIL rr_sb got p=%0d id=%0d exp p=%0d id=%0d", s_op, s_oid, e.p, e.id);
          end
        end
      end
    end
    n_vec++;
    if (sb.size() != 0) begin n_err++; $display("FAIL rr_drain left=%0d exp 0", sb.size()); end
  endtask

  task automatic test_back_to_back_stall();
    exp_t e, head;
    int ret = 0;
    randomize_ops();
    bus.req_valid = 4'b0001; tick();
    bus.req_valid = 4'b0010; tick();
    n_vec++;
    if (sb.size() != 2) begin n_err++; $display("FAIL bp_issue inflight=%0d exp 2", sb.size()); end
    head = sb[0];
    bus.out_ready = 1'b0; bus.req_valid = '1;
    randomize_ops();
    repeat (5) begin
      tick();
      n_vec++;
      if (s_en !== 1'b0 || s_rdy !== 4'b0000 || s_ov !== 1'b1 || s_op !== head.p || s_oid !== 2'd0) begin
        n_err++;
        $display("FAIL bp_stall en=%b rdy=%b ov=%b p=%0d id=%0d exp 0 0000 1 %0d 0", s_en, s_rdy, s_ov, s_op, s_oid, head.p);
      end
    end
    bus.out_ready = 1'b1; bus.req_valid = '0;
    repeat (3) begin
      tick();
      if (s_ov && s_ordy) begin
        n_vec++; ret++;
        if (sb.size() == 0) begin n_err++; $display("FAIL bp_sb unexpected p=%0d id=%0d", s_op, s_oid); end
        else begin
          e = sb.pop_front();
          if (s_op !== e.p || s_oid !== e.id) begin
            n_err++; $display("FAIL bp_sb got p=%0d id=%0d exp p=%0d id=%0d", s_op, s_oid, e.p, e.id);
          end
        end
      end
    end
    n_vec++;
    if (ret != 2 || sb.size() != 0) begin n_err++; $display("FAIL bp_drain retired=%0d left=%0d exp 2 0", ret, sb.size()); end
  endtask

  task automatic test_rr_ptr3();
    exp_t e;
    logic [N_REQ-1:0] exp_rdy [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b1000};
    randomize_ops();
    for (int k = 0; k < 7; k++) begin
      bus.req_valid = (k == 0) ? 4'b0100 : (k < 4) ? 4'b1001 : 4'b0000;
      tick();
      if (k < 4) begin
        n_vec++;
        if (s_rdy !== exp_rdy[k]) begin n_err++; $display("FAIL ptr3_grant k=%0d rdy=%b exp %b", k, s_rdy, exp_rdy[k]); end
      end
      if (s_ov && s_ordy) begin
        n_vec++;
        if (sb.size() == 0) begin n_err++; $display("FAIL ptr3_sb unexpected p=%0d id=%0d", s_op, s_oid); end
        else begin
          e = sb.pop_front();
          if (s_op !== e.p || s_oid !== e.id) begin
            n_err++; $display("FAIL ptr3_sb got p=%0d id=%0d exp p=%0d id=%0d", s_op, s_oid, e.p, e.id);
          end
        end
      end
    end
    n_vec++;
    if (sb.size() != 0) begin n_err++; $display("FAIL ptr3_drain left=%0d exp 0", sb.size()); end
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    int ret = 0;
    randomize_ops();
    bus.req_valid = '1;
    repeat (2) tick();
    bus.req_valid = '0; rst = 1'b1;
    tick();
    n_vec++;
    if (s_ov !== 1'b0 || s_busy !== 1'b0 || s_en !== 1'b1 || s_rdy !== 4'b0000) begin
      n_err++; $display("FAIL rstmid_hold ov=%b busy=%b en=%b rdy=%b exp 0 0 1 0000", s_ov, s_busy, s_en, s_rdy);
    end
    sb.delete();
    rst = 1'b0;
    tick();
    n_vec++;
    if (s_ov !== 1'b0 || s_busy !== 1'b0) begin
      n_err++; $display("FAIL rstmid_clear ov=%b busy=%b exp 0 0", s_ov, s_busy);
    end
    bus.req_valid = '1;
    tick();
    n_vec++;
    if (s_rdy !== 4'b0001) begin n_err++; $display("FAIL rstmid_ptr rdy=%b exp 0001", s_rdy); end
    bus.req_valid = '0;
    repeat (4) begin
      tick();
      if (s_ov && s_ordy) begin
        n_vec++; ret++;
        if (sb.size() == 0) begin n_err++; $display("FAIL rstmid_sb stale p=%0d id=%0d", s_op, s_oid); end
        else begin
          e = sb.pop_front();
          if (s_op !== e.p || s_oid !== e.id) begin
            n_err++; $display("FAIL rstmid_sb got p=%0d id=%0d exp p=%0d id=%0d", s_op, s_oid, e.p, e.id);
          end
        end
      end
    end
    n_vec++;
    if (ret != 1) begin n_err++; $display("FAIL rstmid_count retired=%0d exp 1", ret); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N_REQ; i++) begin op_a[i] = '0; op_b[i] = '0; end
    rst = 1'b1; bus.req_valid = '0; bus.out_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back_stall();
    test_rr_ptr3();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dadda_mul_arbiter.md
Name: dadda_mul_arbiter

Overview:
- Shares one pipelined signed BIT_NUM x BIT_NUM modified-Dadda multiplier among N_REQ requesters.
- Arbitration is round-robin, with one operand pair issued per enabled cycle.
- Each issue's requester ID travels through a tag pipeline aligned to the multiplier latency, so every product returns tagged with its source.
- A single result port has back-pressure; a stalled result freezes the whole multiplier pipeline through mul_en.

Parameters:
- BIT_NUM, 11, operand width in bits, signed two's complement.
- P_W, 2*BIT_NUM+1 (23), product width; matches the multiplier output.
- N_REQ, 4, number of requesters; minimum 2.
- MUL_LAT, 2, multiplier pipeline depth in enabled clock edges; minimum 1.
- ID_W, $clog2(N_REQ), width of the requester tag.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  one-hot grant; the handshake for requester i completes when req_valid[i] and req_ready[i] are both high.
- req_a  in  N_REQ*BIT_NUM  packed operand A; slice i belongs to requester i.
- req_b  in  N_REQ*BIT_NUM  packed operand B.
- mul_a  out  BIT_NUM  operand A to the multiplier.
- mul_b  out  BIT_NUM  operand B to the multiplier.
- mul_en  out  1  pipeline-register enable for the multiplier.
- mul_p  in  P_W  multiplier product, valid MUL_LAT enabled edges after its operands were issued.
- out_valid  out  1  result valid.
- out_ready  in  1  result accept.
- out_p  out  P_W  product, driven directly from mul_p.
- out_id  out  ID_W  source requester of out_p.
- busy  out  1  high when any pipeline stage holds a valid entry.

Behaviour:
- Pipeline state:
  - vld_sr[0..MUL_LAT-1] and id_sr[0..MUL_LAT-1] are registers.
  - rr_ptr is an ID_W-bit register.
- Reset: vld_sr is all 0, id_sr is all 0, rr_ptr is 0.
  - While rst is high: req_ready=0, out_valid=0, busy=0, mul_en=1, mul_a=0, mul_b=0.
- Stall logic: mul_en = !(vld_sr[MUL_LAT-1] && !out_ready). This is combinational.
- Grant selection, only when mul_en=1 and rst=0:
  - g is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... and wrapping modulo N_REQ.
  - req_ready = one-hot(g); 0 if no request is valid or mul_en=0.
  - req_ready is combinational from req_valid, rr_ptr and mul_en.
- Operand mux:
  - On a grant: mul_a = req_a[g], mul_b = req_b[g].
  - Otherwise mul_a=0 and mul_b=0; this keeps the tree inputs quiet.
- Advance on each edge with mul_en=1:
  - vld_sr[0] <= grant_any, id_sr[0] <= g.
  - vld_sr[k] <= vld_sr[k-1] and id_sr[k] <= id_sr[k-1].
  - rr_ptr <= (g+1) mod N_REQ if grant_any; otherwise rr_ptr holds.
- With mul_en=0, all of vld_sr, id_sr and rr_ptr hold.
- Result port:
  - out_valid = vld_sr[MUL_LAT-1], out_id = id_sr[MUL_LAT-1], out_p = mul_p.
  - Latency from a request handshake at edge t to out_valid is MUL_LAT edges, absent stalls.
- Back-pressure: out_valid stays high and out_p/out_id stay stable until out_ready. During a stall no new grant is issued.
- Simultaneous accept and issue: if out_ready=1 while the tail is valid, mul_en=1, so the tail retires and a new grant is issued in the same cycle. Full throughput is 1 product per cycle.
- Fairness: a continuously-asserting requester waits at most N_REQ-1 grants.
- Non-power-of-2 N_REQ: the wrap is explicit. rr_ptr = N_REQ-1 followed by a grant goes to 0; rr_ptr never reaches N_REQ.
- Requester rules:
  - A requester may drop req_valid without a grant.
  - Operands are sampled only in the cycle of the handshake.
- Reset mid-operation: all in-flight entries are discarded (vld_sr cleared). No out_valid is produced for them.
- busy = OR of vld_sr.

Test Plan:
- Reset release, no requests -> req_ready=0000, out_valid=0, busy=0, mul_en=1 for 10 cycles.
- Single request: req 2 issues a=-1024, b=-1024 at cycle 0 -> out_valid at cycle 2, out_p=1048576, out_id=2. Also a=1023, b=-1 -> out_p=-1023.
- All 4 requesters valid continuously, out_ready=1 -> grants 0,1,2,3,0,1,... with one out_valid per cycle from cycle 2; out_id follows the same sequence.
- out_ready held low for 5 cycles while 2 results are in flight -> mul_en=0, req_ready=0, out_p/out_id stable. On release, results drain in order with no loss or duplication.
- Grant pattern with rr_ptr=3: req_valid=1001 -> grant requester 3, then 0, then 3. Requester 0 is never starved.
- Assert rst for 1 cycle with 2 products in flight -> out_valid=0, busy=0, rr_ptr=0 after the edge; no stale result appears later.
